// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg: class codes, MIPS opcode/funct constants, mode/state encodings,
// the trace entry layout and the instruction classifier shared by the trace buffer.
package mips_trace_pkg;

    localparam logic [3:0] CLS_EMPTY = 4'd0, CLS_NOP = 4'd1, CLS_ADD = 4'd2, CLS_SUB = 4'd3,
                           CLS_AND = 4'd4, CLS_OR = 4'd5, CLS_SLT = 4'd6, CLS_SRL = 4'd7,
                           CLS_LW = 4'd8, CLS_SW = 4'd9, CLS_BEQ = 4'd10, CLS_J = 4'd11,
                           CLS_ADDIU = 4'd12, CLS_OTHER = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'd0, OP_LW = 6'd35, OP_SW = 6'd43, OP_BEQ = 6'd4,
                           OP_J = 6'd2, OP_ADDIU = 6'd9;

    localparam logic [5:0] FN_ADD = 6'd32, FN_SUB = 6'd34, FN_AND = 6'd36, FN_OR = 6'd37,
                           FN_SLT = 6'd42, FN_SRL = 6'd2;

    typedef enum logic [1:0] {MODE_WRAP, MODE_FILL, MODE_TRIG, MODE_RSVD} mode_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wd;
        logic [3:0]  cls;
    } entry_t;

    function automatic logic [3:0] classify(input logic [31:0] instr);
        if (instr == '0) return CLS_NOP;
        if (instr[31:26] == OP_RTYPE)
            case (instr[5:0])
                FN_ADD:  return CLS_ADD;
                FN_SUB:  return CLS_SUB;
                FN_AND:  return CLS_AND;
                FN_OR:   return CLS_OR;
                FN_SLT:  return CLS_SLT;
                FN_SRL:  return CLS_SRL;
                default: return CLS_OTHER;
            endcase
        case (instr[31:26])
            OP_LW:    return CLS_LW;
            OP_SW:    return CLS_SW;
            OP_BEQ:   return CLS_BEQ;
            OP_J:     return CLS_J;
            OP_ADDIU: return CLS_ADDIU;
            default:  return CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/mips_trace_buffer_ring.sv
// trace_ring: DEPTH-entry circular trace store with head/tail/count.
// Ports: clr_i empties the ring, push_i writes wr_i at the tail, pop_i pops the head
// (ignored when empty), wrap_i lets a push into a full ring overwrite the oldest entry.
// head_o is the head entry (zero when empty); drop_o flags an overwrite, fill_o a write
// that makes the ring full.
module trace_ring
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   wrap_i,
    input  entry_t wr_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o,
    output logic   drop_o,
    output logic   fill_o
);
    localparam int AW = $clog2(DEPTH);
    entry_t mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0] cnt_q;
    logic do_pop, do_push;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    // A full ring accepts a push only if it pops in the same cycle or may overwrite.
    assign drop_o  = push_i && full_o && !do_pop && wrap_i;
    assign do_push = push_i && (!full_o || do_pop || wrap_i);
    assign fill_o  = do_push && !do_pop && cnt_q == (AW+1)'(DEPTH - 1);
    assign head_o  = empty_o ? '0 : mem_q[head_q];
    always_ff @(posedge clk)
        if (do_push) mem_q[tail_q] <= wr_i;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + AW'(1);
            if (do_pop || drop_o) head_q <= head_q + AW'(1);
            if (do_push && !do_pop && !drop_o) cnt_q <= cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
        end
endmodule

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: writeback-stage instruction trace capture with WRAP/FILL/TRIG modes.
// Ports: cap_* retiring instruction tap; cfg_* capture config latched on arm; arm/stop
// session pulses; rd_* valid/ready head-entry read port; full/empty ring status;
// state FSM state; cnt_cap/cnt_drop saturating capture and overwrite counters.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_valid,
    input  logic [31:0]      cap_pc,
    input  logic [31:0]      cap_instr,
    input  logic [31:0]      cap_wd,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_skip_nop,
    input  logic [31:0]      cfg_trig_pc,
    input  logic             arm,
    input  logic             stop,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [31:0]      rd_pc,
    output logic [31:0]      rd_instr,
    output logic [31:0]      rd_wd,
    output logic [3:0]       rd_class,
    output logic             full,
    output logic             empty,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cnt_cap,
    output logic [CNT_W-1:0] cnt_drop
);
    state_e state_q;
    mode_e mode_q;
    logic skip_q;
    logic [31:0] trig_q;
    logic [CNT_W-1:0] cnt_cap_q, cnt_cap_d, cnt_drop_q, cnt_drop_d;
    entry_t wr, head;
    logic trig_hit, qual, drop, fill;
    assign wr = {cap_pc, cap_instr, cap_wd, classify(cap_instr)};
    assign trig_hit = cap_valid && state_q == ST_ARMED && cap_pc == trig_q;
    // The triggering instruction is captured in the same cycle it moves ARMED to CAPTURE;
    // anything retiring in the arm cycle is discarded.
    assign qual = !arm && cap_valid && (state_q == ST_CAPTURE || trig_hit) &&
                  !(skip_q && wr.cls == CLS_NOP);
    trace_ring #(.DEPTH(DEPTH)) u_ring (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (arm),
        .push_i  (qual),
        .pop_i   (rd_ready),
        .wrap_i  (mode_q == MODE_WRAP),
        .wr_i    (wr),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .drop_o  (drop),
        .fill_o  (fill)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_WRAP;
            skip_q  <= 1'b0;
            trig_q  <= '0;
        end else if (arm) begin
            state_q <= cfg_mode == MODE_TRIG ? ST_ARMED : ST_CAPTURE;
            mode_q  <= mode_e'(cfg_mode);
            skip_q  <= cfg_skip_nop;
            trig_q  <= cfg_trig_pc;
        end else if (stop && (state_q == ST_ARMED || state_q == ST_CAPTURE))
            state_q <= ST_DONE;
        else if (trig_hit)
            state_q <= ST_CAPTURE;
        else if (state_q == ST_CAPTURE && mode_q != MODE_WRAP && fill)
            state_q <= ST_DONE;
    always_comb begin
        cnt_cap_d  = arm ? '0 : cnt_cap_q + CNT_W'(qual && ~&cnt_cap_q);
        cnt_drop_d = arm ? '0 : cnt_drop_q + CNT_W'(drop && ~&cnt_drop_q);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_cap_q  <= '0;
            cnt_drop_q <= '0;
        end else begin
            cnt_cap_q  <= cnt_cap_d;
            cnt_drop_q <= cnt_drop_d;
        end
    assign rd_valid = !empty;
    assign rd_pc    = head.pc;
    assign rd_instr = head.instr;
    assign rd_wd    = head.wd;
    assign rd_class = head.cls;
    assign state    = state_q;
    assign cnt_cap  = cnt_cap_q;
    assign cnt_drop = cnt_drop_q;
endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer: directed and random stimulus checked against a queue-based model.
module tb_mips_trace_buffer;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic clk = 0, rst = 0, cap_valid = 0, cfg_skip_nop = 0, arm = 0, stop = 0, rd_ready = 0;
    logic [31:0] cap_pc = 0, cap_instr = 0, cap_wd = 0, cfg_trig_pc = 0;
    logic [1:0] cfg_mode = 0;
    logic rd_valid, full, empty;
    logic [31:0] rd_pc, rd_instr, rd_wd;
    logic [3:0] rd_class;
    logic [1:0] state;
    logic [CNT_W-1:0] cnt_cap, cnt_drop;

    mips_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
        .cap_wd(cap_wd), .cfg_mode(cfg_mode), .cfg_skip_nop(cfg_skip_nop),
        .cfg_trig_pc(cfg_trig_pc), .arm(arm), .stop(stop), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wd(rd_wd),
        .rd_class(rd_class), .full(full), .empty(empty), .state(state),
        .cnt_cap(cnt_cap), .cnt_drop(cnt_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr, wd;
        logic [3:0] cls;
    } ent_t;

    ent_t q[$];
    int m_state = 0, m_mode = 0, m_cap = 0, m_drop = 0;
    logic m_skip = 0;
    logic [31:0] m_trig = 0;
    int errors = 0, checks = 0;

    function automatic logic [3:0] ref_class(input logic [31:0] i);
        int op, fn;
        op = int'(i[31:26]);
        fn = int'(i[5:0]);
        if (i == 0) return 1;
        if (op == 0) begin
            if (fn == 32) return 2;
            if (fn == 34) return 3;
            if (fn == 36) return 4;
            if (fn == 37) return 5;
            if (fn == 42) return 6;
            if (fn == 2) return 7;
            return 13;
        end
        if (op == 35) return 8;
        if (op == 43) return 9;
        if (op == 4) return 10;
        if (op == 2) return 11;
        if (op == 9) return 12;
        return 13;
    endfunction

    function automatic logic [31:0] mk(input int op, input int fn);
        return {6'(op), 5'd1, 5'd2, 5'd3, 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] pick_instr(input int k);
        case (k)
            0: return 32'h0;
            1: return mk(0, 32);
            2: return mk(0, 34);
            3: return mk(0, 36);
            4: return mk(0, 37);
            5: return mk(0, 42);
            6: return mk(0, 2);
            7: return mk(35, 5);
            8: return mk(43, 6);
            9: return mk(4, 7);
            10: return mk(2, 8);
            11: return mk(9, 9);
            12: return mk(0, 13);
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0;
        m_cap = 0;
        m_drop = 0;
    endtask

    // Next-cycle model from the current inputs, following the capture rules directly.
    task automatic model_step();
        bit popped, hit, qual;
        int nxt;
        ent_t e;
        if (arm) begin
            q.delete();
            m_cap = 0;
            m_drop = 0;
            m_mode = cfg_mode == 3 ? 1 : int'(cfg_mode);
            m_skip = cfg_skip_nop;
            m_trig = cfg_trig_pc;
            m_state = m_mode == 2 ? 1 : 2;
            return;
        end
        e = '{pc: cap_pc, instr: cap_instr, wd: cap_wd, cls: ref_class(cap_instr)};
        popped = rd_ready && q.size() > 0;
        hit = cap_valid && m_state == 1 && cap_pc == m_trig;
        qual = cap_valid && (m_state == 2 || hit) && !(m_skip && e.cls == 1);
        nxt = m_state;
        if (stop && (m_state == 1 || m_state == 2)) nxt = 3;
        else if (hit) nxt = 2;
        if (popped) void'(q.pop_front());
        if (qual) begin
            if (m_cap < 2**CNT_W - 1) m_cap++;
            if (q.size() == DEPTH) begin
                if (m_mode == 0) begin
                    void'(q.pop_front());
                    q.push_back(e);
                    if (m_drop < 2**CNT_W - 1) m_drop++;
                end
            end else begin
                q.push_back(e);
                if (q.size() == DEPTH && !popped && m_mode != 0 && m_state == 2 && nxt == 2)
                    nxt = 3;
            end
        end
        m_state = nxt;
    endtask

    task automatic compare_all();
        ent_t h;
        h = '{pc: 0, instr: 0, wd: 0, cls: 0};
        if (q.size() > 0) h = q[0];
        chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("rd_pc", rd_pc, h.pc);
        chk("rd_instr", rd_instr, h.instr);
        chk("rd_wd", rd_wd, h.wd);
        chk("rd_class", 32'(rd_class), 32'(h.cls));
        chk("state", 32'(state), 32'(m_state));
        chk("cnt_cap", 32'(cnt_cap), 32'(m_cap));
        chk("cnt_drop", 32'(cnt_drop), 32'(m_drop));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        arm = 0;
        stop = 0;
        cap_valid = 0;
        rd_ready = 0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic rdy);
        cap_valid = 1;
        cap_pc = pc;
        cap_instr = instr;
        cap_wd = $urandom;
        rd_ready = rdy;
        tick();
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic skip, input logic [31:0] trig);
        cfg_mode = mode;
        cfg_skip_nop = skip;
        cfg_trig_pc = trig;
        arm = 1;
        tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            rd_ready = 1;
            tick();
        end
    endtask

    initial begin
        rst = 1;
        #12;
        chk("reset_state", 32'(state), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_rd_pc", rd_pc, 0);
        chk("reset_cnt_cap", 32'(cnt_cap), 0);
        model_reset();
        rst = 0;
        @(posedge clk);
        #1;
        compare_all();

        // WRAP overflow
        do_arm(2'd0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) retire(32'(i * 4), mk(0, 32), 1'b0);
        chk("wrap_full", 32'(full), 1);
        chk("wrap_cnt_cap", 32'(cnt_cap), 20);
        chk("wrap_cnt_drop", 32'(cnt_drop), 4);
        chk("wrap_head_pc", rd_pc, 32'h10);
        chk("wrap_head_class", 32'(rd_class), 2);

        // Full with simultaneous push and pop
        retire(32'h50, mk(0, 32), 1'b1);
        chk("fullpop_full", 32'(full), 1);
        chk("fullpop_cnt_drop", 32'(cnt_drop), 4);
        chk("fullpop_head_pc", rd_pc, 32'h14);
        drain(17);

        // FILL stop
        do_arm(2'd1, 1'b0, 32'h0);
        for (int i = 0; i < 16; i++) retire(32'h100 + 32'(i * 4), mk(35, i), 1'b0);
        chk("fill_state_done", 32'(state), 3);
        for (int i = 0; i < 3; i++) retire(32'h200 + 32'(i * 4), mk(35, 0), 1'b0);
        chk("fill_cnt_cap", 32'(cnt_cap), 16);
        chk("fill_cnt_drop", 32'(cnt_drop), 0);
        chk("fill_head_pc", rd_pc, 32'h100);
        drain(16);

        // TRIG
        do_arm(2'd2, 1'b0, 32'h40);
        for (int i = 0; i <= 24; i++) begin
            if (i * 4 <= 32'h40) chk("trig_armed", 32'(state), 1);
            retire(32'(i * 4), mk(0, 34), 1'b0);
        end
        chk("trig_cnt_cap", 32'(cnt_cap), 9);
        chk("trig_head_pc", rd_pc, 32'h40);
        drain(9);

        // Skip-NOP
        do_arm(2'd0, 1'b1, 32'h0);
        for (int i = 0; i < 6; i++) retire(32'h300 + 32'(i * 4), i % 2 == 0 ? 32'h0 : mk(43, 1), 1'b0);
        chk("skip_cnt_cap", 32'(cnt_cap), 3);
        for (int i = 0; i < 3; i++) begin
            chk("skip_class", 32'(rd_class), 9);
            rd_ready = 1;
            tick();
        end
        chk("skip_drained", 32'(empty), 1);

        // arm and stop together
        retire(32'h400, mk(0, 36), 1'b0);
        cfg_mode = 2'd0;
        arm = 1;
        stop = 1;
        tick();
        chk("armstop_state", 32'(state), 2);
        chk("armstop_empty", 32'(empty), 1);

        // Async reset mid-capture
        for (int i = 0; i < 5; i++) retire(32'h500 + 32'(i * 4), mk(0, 37), 1'b0);
        rst = 1;
        #1;
        chk("arst_empty", 32'(empty), 1);
        chk("arst_state", 32'(state), 0);
        chk("arst_cnt_cap", 32'(cnt_cap), 0);
        model_reset();
        #2;
        rst = 0;
        @(posedge clk);
        #1;
        compare_all();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            arm = $urandom_range(0, 39) == 0;
            stop = $urandom_range(0, 29) == 0;
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_skip_nop = 1'($urandom_range(0, 1));
            cfg_trig_pc = 32'($urandom_range(0, 15) * 4);
            cap_valid = $urandom_range(0, 3) != 0;
            cap_pc = 32'($urandom_range(0, 15) * 4);
            cap_instr = pick_instr($urandom_range(0, 13));
            cap_wd = $urandom;
            rd_ready = $urandom_range(0, 2) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
